alu_input_sequencer: RTL

- Board-level front end for the existing `alu`.
- Loads operand A, operand B and the opcode from shared switches. Loading is driven by synchronised, edge-detected pushbuttons rather than level-sensitive ones.
- Tracks which fields hold data and gates a registered result with a valid flag.
- Adds a clear button. Sits between FPGA pins (switches, buttons, LEDs) and the `alu` instance it owns.

---
 rtl/alu_pkg.sv | 48 ++++
 rtl/alu.sv | 39 +++
 rtl/btn_edge_sync.sv | 74 +++++++
 rtl/alu_input_sequencer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU and its board-level input sequencer:
//   - opcode encodings understood by `alu`
//   - sequencer FSM state encoding
//   - bit positions inside the {code, dato2, dato1} loaded mask
//   - helper that tells whether exactly one load request is active
// Optional feature macro used by the importing files: ALU_SEQ_DEBOUNCE_EN.
// ---------------------------------------------------------------------------
package alu_pkg;

  // Opcode field width produced by the encodings below
  localparam int unsigned NB_OPC = 6;

  // ALU opcodes
  localparam logic [NB_OPC-1:0] ADD = 6'b100000;
  localparam logic [NB_OPC-1:0] SUB = 6'b100010;
  localparam logic [NB_OPC-1:0] AND = 6'b100100;
  localparam logic [NB_OPC-1:0] OR  = 6'b100101;
  localparam logic [NB_OPC-1:0] XOR = 6'b100110;
  localparam logic [NB_OPC-1:0] SRA = 6'b000011;
  localparam logic [NB_OPC-1:0] SRL = 6'b000010;
  localparam logic [NB_OPC-1:0] NOR = 6'b100111;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    COMPUTE = 2'd1,
    SHOW    = 2'd2
  } seq_state_t;

  // Loaded-mask layout: {code, dato2, dato1}
  localparam int unsigned NB_LOADED = 3;
  localparam int unsigned LD_DATO1  = 0;
  localparam int unsigned LD_DATO2  = 1;
  localparam int unsigned LD_CODE   = 2;

  localparam logic [NB_LOADED-1:0] LOADED_NONE = 3'b000;
  localparam logic [NB_LOADED-1:0] LOADED_ALL  = 3'b111;

  // True when exactly one bit of the load-request vector is set
  function automatic logic is_single_load(input logic [NB_LOADED-1:0] req);
    logic [NB_LOADED-1:0] low;
    low = req - NB_LOADED'(1);
    return (req != LOADED_NONE) && ((req & low) == LOADED_NONE);
  endfunction

endpackage

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu
// Purely combinational ALU selected by a MIPS-style function code.
// Arithmetic wraps modulo 2^NB_DATA; no carry or overflow is reported.
// Unknown opcodes return 0.
// Ports:
//   a, b      in   NB_DATA  operands (b is the shift amount for SRA/SRL)
//   op        in   NB_CODE  opcode
//   result_c  out  NB_DATA  combinational result
// ---------------------------------------------------------------------------
module alu
  import alu_pkg::*;
#(
  parameter int unsigned NB_DATA = 8,
  parameter int unsigned NB_CODE = NB_OPC
) (
  input  logic [NB_DATA-1:0] a,
  input  logic [NB_DATA-1:0] b,
  input  logic [NB_CODE-1:0] op,
  output logic [NB_DATA-1:0] result_c
);

  // Opcode decode
  always_comb begin
    result_c = '0;
    case (op)
      NB_CODE'(ADD): result_c = a + b;
      NB_CODE'(SUB): result_c = a - b;
      NB_CODE'(AND): result_c = a & b;
      NB_CODE'(OR):  result_c = a | b;
      NB_CODE'(XOR): result_c = a ^ b;
      NB_CODE'(SRA): result_c = NB_DATA'($signed(a) >>> b);
      NB_CODE'(SRL): result_c = a >> b;
      NB_CODE'(NOR): result_c = ~(a | b);
      default:       result_c = '0;
    endcase
  end

endmodule

// File: rtl/btn_edge_sync.sv
// ---------------------------------------------------------------------------
// btn_edge_sync
// Conditions one asynchronous pushbutton into a single-cycle pulse:
//   NB_SYNC-stage synchroniser -> optional debouncer -> rising-edge pulse.
// A held button yields exactly one pulse.
// Pin-to-pulse latency: NB_SYNC+1 cycles, or NB_SYNC + 2^NB_DBNC + 1 cycles
// when ALU_SEQ_DEBOUNCE_EN is defined.
// Optional feature macro: ALU_SEQ_DEBOUNCE_EN (adds the debouncer and the
// NB_DBNC parameter).
// Ports:
//   clk    in   1  system clock
//   reset  in   1  synchronous active-high reset
//   btn    in   1  asynchronous button pin
//   pulse  out  1  registered one-cycle pulse on a press
// ---------------------------------------------------------------------------
module btn_edge_sync #(
  parameter int unsigned NB_SYNC = 2
`ifdef ALU_SEQ_DEBOUNCE_EN
  , parameter int unsigned NB_DBNC = 16
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic [NB_SYNC-1:0] sync;
  logic               level;    // conditioned level seen by the edge detector
  logic               level_d;

  // Metastability synchroniser; sync[NB_SYNC-1] is the settled sample
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '0;
    end else begin
      sync <= {sync[NB_SYNC-2:0], btn};
    end
  end

`ifdef ALU_SEQ_DEBOUNCE_EN
  logic [NB_DBNC-1:0] stable_cnt;

  // Level follows the synchroniser only after 2^NB_DBNC agreeing cycles;
  // any return to the current level restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable_cnt <= '0;
      level      <= 1'b0;
    end else if (sync[NB_SYNC-1] == level) begin
      stable_cnt <= '0;
    end else if (stable_cnt == '1) begin
      stable_cnt <= '0;
      level      <= sync[NB_SYNC-1];
    end else begin
      stable_cnt <= stable_cnt + NB_DBNC'(1);
    end
  end
`else
  assign level = sync[NB_SYNC-1];
`endif

  // Rising-edge detector with registered pulse output
  always_ff @(posedge clk) begin
    if (reset) begin
      level_d <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      level_d <= level;
      pulse   <= level & ~level_d;
    end
  end

endmodule

// File: rtl/alu_input_sequencer.sv
// ---------------------------------------------------------------------------
// alu_input_sequencer
// Board front end for `alu`: loads operand A, operand B and the opcode from
// shared switches on conditioned button presses, tracks which fields are
// loaded, and presents a registered result qualified by o_valid.
// Last load pulse in cycle k -> register at k+1 -> o_result/o_valid at k+2.
// Optional feature macro: ALU_SEQ_DEBOUNCE_EN (button debouncing, adds the
// NB_DBNC parameter).
// Ports:
//   clk       in   1       system clock
//   reset     in   1       synchronous active-high reset
//   switch    in   NB_IN   data switches (opcode from switch[NB_CODE-1:0])
//   b_dato1   in   1       button: load operand A
//   b_dato2   in   1       button: load operand B
//   b_code    in   1       button: load opcode
//   b_clear   in   1       button: clear loaded flags / valid
//   o_loaded  out  3       {code, dato2, dato1} loaded flags
//   o_valid   out  1       o_result matches the current A/B/opcode
//   o_result  out  NB_OUT  registered ALU result
// ---------------------------------------------------------------------------
module alu_input_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned NB_IN   = 8,
  parameter int unsigned NB_OUT  = 8,
  parameter int unsigned NB_CODE = 6,
  parameter int unsigned NB_SYNC = 2
`ifdef ALU_SEQ_DEBOUNCE_EN
  , parameter int unsigned NB_DBNC = 16
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NB_IN-1:0]     switch,
  input  logic                 b_dato1,
  input  logic                 b_dato2,
  input  logic                 b_code,
  input  logic                 b_clear,
  output logic [NB_LOADED-1:0] o_loaded,
  output logic                 o_valid,
  output logic [NB_OUT-1:0]    o_result
);

  localparam int unsigned NB_BTN    = 4;
  localparam int unsigned BTN_CLEAR = 3;

  logic [NB_BTN-1:0]    btn;
  logic [NB_BTN-1:0]    pulse;
  logic [NB_LOADED-1:0] load_req;
  logic                 p_clear;
  logic                 load_ok;
  logic [NB_LOADED-1:0] loaded_next;

  seq_state_t state;
  seq_state_t state_next;

  logic ld_dato1;
  logic ld_dato2;
  logic ld_code;
  logic capture;
  logic valid_next;

  logic [NB_IN-1:0]   r_dato1;
  logic [NB_IN-1:0]   r_dato2;
  logic [NB_CODE-1:0] r_code;
  logic [NB_IN-1:0]   alu_result_c;

  // Button order matches the loaded-mask layout; clear sits above it
  assign btn[LD_DATO1]  = b_dato1;
  assign btn[LD_DATO2]  = b_dato2;
  assign btn[LD_CODE]   = b_code;
  assign btn[BTN_CLEAR] = b_clear;

  // One conditioner per button
  for (genvar i = 0; i < NB_BTN; i++) begin : g_btn
    btn_edge_sync #(
      .NB_SYNC (NB_SYNC)
`ifdef ALU_SEQ_DEBOUNCE_EN
      , .NB_DBNC (NB_DBNC)
`endif
    ) u_btn (
      .clk   (clk),
      .reset (reset),
      .btn   (btn[i]),
      .pulse (pulse[i])
    );
  end

  assign load_req = pulse[NB_LOADED-1:0];
  assign p_clear  = pulse[BTN_CLEAR];

  // Simultaneous load requests are ambiguous and dropped; clear wins over all
  assign load_ok = is_single_load(load_req) && !p_clear;

  // Loaded-mask update
  always_comb begin
    loaded_next = o_loaded;
    if (p_clear) begin
      loaded_next = LOADED_NONE;
    end else if (load_ok) begin
      loaded_next = o_loaded | load_req;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= COLLECT;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state; COLLECT leaves on the pulse that completes the mask so
  // COMPUTE coincides with the first cycle all three registers are valid
  always_comb begin
    state_next = state;
    if (p_clear) begin
      state_next = COLLECT;
    end else begin
      case (state)
        COLLECT: if (loaded_next == LOADED_ALL) state_next = COMPUTE;
        COMPUTE: state_next = load_ok ? COMPUTE : SHOW;
        SHOW:    if (load_ok) state_next = COMPUTE;
        default: state_next = COLLECT;
      endcase
    end
  end

  // FSM outputs: register enables, result capture and next valid
  always_comb begin
    ld_dato1   = 1'b0;
    ld_dato2   = 1'b0;
    ld_code    = 1'b0;
    capture    = 1'b0;
    valid_next = 1'b0;
    if (load_ok) begin
      ld_dato1 = load_req[LD_DATO1];
      ld_dato2 = load_req[LD_DATO2];
      ld_code  = load_req[LD_CODE];
    end
    capture    = (state == COMPUTE) && !p_clear;
    valid_next = (state_next == SHOW);
  end

  // Operand/opcode registers and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dato1  <= '0;
      r_dato2  <= '0;
      r_code   <= '0;
      o_loaded <= LOADED_NONE;
      o_valid  <= 1'b0;
      o_result <= '0;
    end else begin
      if (ld_dato1) r_dato1 <= switch;
      if (ld_dato2) r_dato2 <= switch;
      if (ld_code)  r_code  <= switch[NB_CODE-1:0];
      o_loaded <= loaded_next;
      o_valid  <= valid_next;
      if (capture) o_result <= NB_OUT'(alu_result_c);
    end
  end

  alu #(
    .NB_DATA (NB_IN),
    .NB_CODE (NB_CODE)
  ) u_alu (
    .a        (r_dato1),
    .b        (r_dato2),
    .op       (r_code),
    .result_c (alu_result_c)
  );

endmodule
